// File: rtl/target_report_if.sv
// Event and report bus of the target_report plot extractor.
interface target_report_if #(
  parameter int RANGE_W    = 10,
  parameter int BEAR_W     = 12,
  parameter int DEPTH_LOG2 = 4
);
  logic                clr;
  logic                target_start;
  logic                target_end;
  logic [RANGE_W-1:0]  range;
  logic [BEAR_W-1:0]   bear;
  logic                ready;
  logic                rpt_valid;
  logic [RANGE_W-1:0]  rpt_range;
  logic [BEAR_W-1:0]   rpt_bear;
  logic [BEAR_W-1:0]   rpt_width;
  logic                rpt_rden;
  logic [DEPTH_LOG2:0] rpt_count;
  logic [7:0]          drop_cnt;

  modport master (
    output clr, target_start, target_end, range, bear, rpt_rden,
    input  ready, rpt_valid, rpt_range, rpt_bear, rpt_width, rpt_count, drop_cnt
  );

  modport slave (
    input  clr, target_start, target_end, range, bear, rpt_rden,
    output ready, rpt_valid, rpt_range, rpt_bear, rpt_width, rpt_count, drop_cnt
  );
endinterface

// File: rtl/target_report.sv
// Plot extractor: pairs target_start/target_end per range cell into
// {range, centre bearing, width} reports queued in a show-ahead FIFO.
module target_report #(
  parameter int RANGE_W    = 10,
  parameter int BEAR_W     = 12,
  parameter int DEPTH_LOG2 = 4,
  parameter int MIN_WIDTH  = 2,
  parameter int MAX_WIDTH  = 512
) (
  input  logic           clk,
  input  logic           reset,
  target_report_if.slave bus
);
  localparam int unsigned TBL_N = 2**RANGE_W;
  localparam int unsigned DEPTH = 2**DEPTH_LOG2;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  typedef struct packed {
    logic              valid;
    logic [BEAR_W-1:0] bear;
  } entry_t;

  typedef struct packed {
    logic [RANGE_W-1:0] range;
    logic [BEAR_W-1:0]  bear;
    logic [BEAR_W-1:0]  width;
  } rpt_t;

  state_t             state;
  logic [RANGE_W-1:0] init_idx;
  logic               ready_q;

  entry_t tbl [TBL_N];

  logic               s1_start, s1_end;
  logic [RANGE_W-1:0] s1_srange, s1_erange;
  logic [BEAR_W-1:0]  s1_sbear, s1_ebear;
  logic               s2_start, s2_end;
  logic [RANGE_W-1:0] s2_srange, s2_erange;
  logic [BEAR_W-1:0]  s2_sbear, s2_ebear;
  entry_t             s2_entry;
  entry_t             rd_fwd;

  logic [BEAR_W-1:0]  width, centre;
  logic               push_req, orphan;

  rpt_t                fifo [DEPTH];
  rpt_t                head;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [7:0]            drop_cnt;
  logic                  full, pop, push, drop;

  // INIT sweep of the start table, then RUN; clr restarts the sweep
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_INIT;
      init_idx <= '0;
      ready_q  <= 1'b0;
    end else if (bus.clr) begin
      state    <= ST_INIT;
      init_idx <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (&init_idx) begin
            state   <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN:  ;
        default: state <= ST_INIT;
      endcase
    end
  end

  // Starts and ends travel the same two-stage pipe so that every table
  // write lands in event order; the read stage only needs to forward the
  // single older event still in stage 2 (start after end within one event).
  always_comb begin
    rd_fwd = tbl[s1_erange];
    if (s2_end && s2_erange == s1_erange)
      rd_fwd = '0;
    if (s2_start && s2_srange == s1_erange)
      rd_fwd = '{valid: 1'b1, bear: s2_sbear};
  end

  // Event pipeline: capture in stage 1, table read result in stage 2
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_start  <= 1'b0;
      s1_end    <= 1'b0;
      s1_srange <= '0;
      s1_erange <= '0;
      s1_sbear  <= '0;
      s1_ebear  <= '0;
      s2_start  <= 1'b0;
      s2_end    <= 1'b0;
      s2_srange <= '0;
      s2_erange <= '0;
      s2_sbear  <= '0;
      s2_ebear  <= '0;
      s2_entry  <= '0;
    end else if (bus.clr) begin
      s1_start <= 1'b0;
      s1_end   <= 1'b0;
      s2_start <= 1'b0;
      s2_end   <= 1'b0;
    end else begin
      s1_start  <= (state == ST_RUN) && bus.target_start;
      s1_end    <= (state == ST_RUN) && bus.target_end;
      s1_srange <= bus.range;
      s1_erange <= bus.range;
      s1_sbear  <= bus.bear;
      s1_ebear  <= bus.bear;
      s2_start  <= s1_start;
      s2_end    <= s1_end;
      s2_srange <= s1_srange;
      s2_erange <= s1_erange;
      s2_sbear  <= s1_sbear;
      s2_ebear  <= s1_ebear;
      s2_entry  <= rd_fwd;
    end
  end

  // Start table: swept clear in INIT; in RUN an end clears, a start opens (start wins)
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      tbl[init_idx] <= '0;
    end else begin
      if (s2_end)
        tbl[s2_erange] <= '0;
      if (s2_start)
        tbl[s2_srange] <= '{valid: 1'b1, bear: s2_sbear};
    end
  end

  // Report arithmetic wraps naturally modulo 2**BEAR_W
  always_comb begin
    width    = s2_ebear - s2_entry.bear;
    centre   = s2_entry.bear + (width >> 1);
    push_req = s2_end && s2_entry.valid &&
               (width >= BEAR_W'(MIN_WIDTH)) && (width <= BEAR_W'(MAX_WIDTH));
    orphan   = s2_end && !s2_entry.valid;
    full     = count[DEPTH_LOG2];
    pop      = bus.rpt_rden && (count != '0);
    push     = push_req && (!full || pop);
    drop     = orphan || (push_req && full && !pop);
    head     = fifo[rd_ptr];
  end

  // FIFO pointers, occupancy and saturating drop counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else if (bus.clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push)
      fifo[wr_ptr] <= '{range: s2_erange, bear: centre, width: width};
  end

  assign bus.ready     = ready_q;
  assign bus.rpt_valid = (count != '0);
  assign bus.rpt_range = bus.rpt_valid ? head.range : '0;
  assign bus.rpt_bear  = bus.rpt_valid ? head.bear  : '0;
  assign bus.rpt_width = bus.rpt_valid ? head.width : '0;
  assign bus.rpt_count = count;
  assign bus.drop_cnt  = drop_cnt;
endmodule
